// File: rtl/cpu_mc_pkg.sv
// Shared opcodes, FSM state encodings and instruction field positions for the multi-cycle core.
// Pure definitions; no timing or flow-control behaviour of its own.
package cpu_mc_pkg;
    localparam int INSTR_W  = 19;
    localparam int NUM_REGS = 8;
    localparam int REG_AW   = 3;

    localparam int OPC_HI = 18;
    localparam int OPC_LO = 14;
    localparam int RD_HI  = 13;
    localparam int RD_LO  = 11;
    localparam int RS1_HI = 10;
    localparam int RS1_LO = 8;
    localparam int RS2_HI = 7;
    localparam int RS2_LO = 5;
    localparam int IMM_HI = 10;
    localparam int TGT_HI = 13;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_LDI  = 5'b00101;
    localparam logic [4:0] OP_BEQ  = 5'b10100;
    localparam logic [4:0] OP_BNE  = 5'b10101;
    localparam logic [4:0] OP_JMP  = 5'b10110;
    localparam logic [4:0] OP_HALT = 5'b11111;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_WB    = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    typedef struct packed {
        logic [4:0]        opc;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [IMM_HI:0]   imm;
        logic [TGT_HI:0]   tgt;
    } instr_t;

    function automatic instr_t decode(input logic [INSTR_W-1:0] ir);
        instr_t d;
        d.opc = ir[OPC_HI:OPC_LO];
        d.rd  = ir[RD_HI:RD_LO];
        d.rs1 = ir[RS1_HI:RS1_LO];
        d.rs2 = ir[RS2_HI:RS2_LO];
        d.imm = ir[IMM_HI:0];
        d.tgt = ir[TGT_HI:0];
        return d;
    endfunction

    // ALU and LDI are the only opcodes that take the WB cycle.
    function automatic logic is_wb_op(input logic [4:0] opc);
        return (opc <= OP_LDI);
    endfunction
endpackage

// File: rtl/cpu_mc_regfile.sv
// Eight-entry register file: two combinational reads, one synchronous write.
// Write lands on the clock edge; reads reflect state immediately, no stall path.
module cpu_mc_regfile
    import cpu_mc_pkg::*;
#(
    parameter int DATA_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);
    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];
endmodule

// File: rtl/cpu_mc_core.sv
// Multi-cycle FETCH/EXEC/WB core: ALU/LDI retire in 3 cycles, branch/JMP/NOP/HALT in 2.
// Fetch holds request and address stable until imem_ack arrives.
module cpu_mc_core
    import cpu_mc_pkg::*;
#(
    parameter int DATA_W = 19,
    parameter int PC_W   = 14
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [DATA_W-1:0]  result,
    output logic               zero,
    output logic               negative,
    output logic               retire,
    output logic               halted
);
    logic [1:0]         state;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    tgt;
    logic [INSTR_W-1:0] ir;
    instr_t             d;
    logic [DATA_W-1:0]  alu_q;
    logic [DATA_W-1:0]  alu_val;
    logic [DATA_W-1:0]  rdata1;
    logic [DATA_W-1:0]  rdata2;

    assign d      = decode(ir);
    assign pc_inc = pc + PC_W'(1);
    assign tgt    = d.tgt[PC_W-1:0];

    cpu_mc_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (state == ST_WB),
        .waddr  (d.rd),
        .wdata  (alu_q),
        .raddr1 (d.rs1),
        .raddr2 (d.rs2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    always_comb begin
        alu_val = '0;
        case (d.opc)
            OP_ADD:  alu_val = rdata1 + rdata2;
            OP_SUB:  alu_val = rdata1 - rdata2;
            OP_AND:  alu_val = rdata1 & rdata2;
            OP_OR:   alu_val = rdata1 | rdata2;
            OP_XOR:  alu_val = rdata1 ^ rdata2;
            OP_LDI:  alu_val = DATA_W'(d.imm);
            default: alu_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_FETCH;
            pc       <= '0;
            ir       <= '0;
            alu_q    <= '0;
            result   <= '0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_data;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (is_wb_op(d.opc)) begin
                        alu_q <= alu_val;
                        state <= ST_WB;
                    end else begin
                        // Flow control resolves here using flags from the last writeback.
                        case (d.opc)
                            OP_BEQ:  pc <= zero ? tgt : pc_inc;
                            OP_BNE:  pc <= zero ? pc_inc : tgt;
                            OP_JMP:  pc <= tgt;
                            OP_HALT: pc <= pc;
                            default: pc <= pc_inc;
                        endcase
                        state <= (d.opc == OP_HALT) ? ST_HALT : ST_FETCH;
                    end
                end
                ST_WB: begin
                    result   <= alu_q;
                    zero     <= (alu_q == '0);
                    negative <= alu_q[DATA_W-1];
                    pc       <= pc_inc;
                    state    <= ST_FETCH;
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_FETCH;
            endcase
        end
    end

    assign imem_req  = (state == ST_FETCH);
    assign imem_addr = pc;
    assign retire    = (state == ST_WB) || ((state == ST_EXEC) && !is_wb_op(d.opc));
    assign halted    = (state == ST_HALT);
endmodule

// File: tb/tb_cpu_mc_core.sv
// Directed plus randomized program bench with an instruction-level reference model.
module tb_cpu_mc_core;
    localparam int DATA_W = 19;
    localparam int PC_W   = 14;
    localparam longint MASK   = (64'd1 << DATA_W) - 1;
    localparam longint PC_MOD = 64'd1 << PC_W;

    localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, LDI = 5'b00101;
    localparam logic [4:0] BEQ = 5'b10100, BNE = 5'b10101, JMP = 5'b10110;
    localparam logic [4:0] HLT = 5'b11111, NOP = 5'b01000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ack = 1'b0;
    logic [18:0]       imem_data = '0;
    logic [DATA_W-1:0] result;
    logic              zero, negative, retire, halted;

    int total = 0;
    int bad   = 0;

    longint m_reg [8];
    longint m_pc, m_res;
    bit     m_z, m_n;

    cpu_mc_core #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .result    (result),
        .zero      (zero),
        .negative  (negative),
        .retire    (retire),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] enc_r(input logic [4:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 5'b0};
    endfunction

    function automatic logic [18:0] enc_i(input logic [4:0] op, input logic [2:0] rd,
                                          input logic [10:0] imm);
        return {op, rd, imm};
    endfunction

    function automatic logic [18:0] enc_j(input logic [4:0] op, input logic [13:0] t);
        return {op, t};
    endfunction

    function automatic logic [18:0] rand_instr();
        logic [4:0]  ops [12] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd5,
                                  5'd20, 5'd21, 5'd22, 5'd9, 5'd30};
        logic [18:0] r;
        r = 19'($urandom);
        r[18:14] = ops[$urandom_range(0, 11)];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 0;
        m_pc = 0; m_res = 0; m_z = 0; m_n = 0;
    endtask

    // kind: 0 = writes a register, 1 = flow/NOP, 2 = HALT
    task automatic model(input logic [18:0] ins, output int kind);
        int op, rd, rs1, rs2;
        longint a, b, v, imm, t;
        op  = int'(ins[18:14]);
        rd  = int'(ins[13:11]);
        rs1 = int'(ins[10:8]);
        rs2 = int'(ins[7:5]);
        imm = longint'(ins[10:0]);
        t   = longint'(ins[13:0]) % PC_MOD;
        a   = m_reg[rs1];
        b   = m_reg[rs2];
        kind = 1;
        v = 0;
        case (op)
            0: v = (a + b) & MASK;
            1: v = (a - b) & MASK;
            2: v = a & b;
            3: v = a | b;
            4: v = a ^ b;
            5: v = imm & MASK;
            default: v = 0;
        endcase
        if (op <= 5) begin
            kind = 0;
            m_reg[rd] = v;
            m_res = v;
            m_z = (v == 0);
            m_n = ((v >> (DATA_W - 1)) & 1) != 0;
            m_pc = (m_pc + 1) % PC_MOD;
        end else if (op == 20) m_pc = m_z ? t : (m_pc + 1) % PC_MOD;
        else if (op == 21)     m_pc = m_z ? (m_pc + 1) % PC_MOD : t;
        else if (op == 22)     m_pc = t;
        else if (op == 31)     kind = 2;
        else                   m_pc = (m_pc + 1) % PC_MOD;
    endtask

    task automatic check_arch(input string tag);
        check({tag, "_addr"}, imem_addr, m_pc);
        check({tag, "_req"}, imem_req, 1);
        check({tag, "_result"}, result, m_res);
        check({tag, "_zero"}, zero, m_z);
        check({tag, "_neg"}, negative, m_n);
        check({tag, "_retire"}, retire, 0);
        check({tag, "_halted"}, halted, 0);
    endtask

    // Entered and left at a falling edge with the core waiting in fetch.
    task automatic exec(input logic [18:0] ins, input int delay);
        int kind;
        for (int i = 0; i < delay; i++) begin
            check("stall_req", imem_req, 1);
            check("stall_addr", imem_addr, m_pc);
            check("stall_retire", retire, 0);
            @(negedge clk);
        end
        check("fetch_req", imem_req, 1);
        check("fetch_addr", imem_addr, m_pc);
        check("fetch_retire", retire, 0);
        imem_ack  = 1'b1;
        imem_data = ins;
        @(negedge clk);
        imem_ack  = 1'b0;
        imem_data = 19'($urandom);
        model(ins, kind);
        check("exec_req", imem_req, 0);
        if (kind == 0) begin
            check("exec_noretire", retire, 0);
            @(negedge clk);
            check("wb_retire", retire, 1);
            check("wb_req", imem_req, 0);
        end else begin
            check("exec_retire", retire, 1);
        end
        @(negedge clk);
        if (kind == 2) begin
            check("halt_halted", halted, 1);
            check("halt_req", imem_req, 0);
        end else begin
            check_arch("post");
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_req", imem_req, 1);
        check("rst_addr", imem_addr, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 0);
        check("rst_neg", negative, 0);
        check("rst_retire", retire, 0);
        check("rst_halted", halted, 0);
        reset = 1'b0;
        check("first_fetch_addr", imem_addr, 0);

        exec(enc_i(LDI, 3'd1, 11'd5), 0);
        exec(enc_i(LDI, 3'd2, 11'd5), 0);
        exec(enc_r(SUB, 3'd3, 3'd1, 3'd2), 0);
        check("sub_eq_result", result, 0);
        check("sub_eq_zero", zero, 1);
        exec(enc_j(BEQ, 14'h020), 0);
        check("beq_taken", imem_addr, 14'h020);
        exec(enc_j(BNE, 14'h020), 0);
        check("bne_not_taken", imem_addr, 14'h021);

        exec(enc_i(LDI, 3'd1, 11'd0), 0);
        exec(enc_i(LDI, 3'd2, 11'd1), 0);
        exec(enc_r(SUB, 3'd3, 3'd1, 3'd2), 0);
        check("sub_neg_result", result, 19'h7FFFF);
        check("sub_neg_flag", negative, 1);
        check("sub_neg_zero", zero, 0);

        exec(enc_j(NOP, 14'h1234), 5);

        exec(enc_j(JMP, 14'h3FFF), 1);
        exec(enc_r(ADD, 3'd4, 3'd1, 3'd2), 0);
        check("pc_wrap", imem_addr, 0);

        for (int n = 0; n < 80; n++) exec(rand_instr(), $urandom_range(0, 2));

        // Reset lands while an ADD is in EXEC.
        exec(enc_i(LDI, 3'd1, 11'd7), 0);
        check("pre_rst_addr", imem_addr, m_pc);
        imem_ack  = 1'b1;
        imem_data = enc_r(ADD, 3'd5, 3'd1, 3'd1);
        @(negedge clk);
        imem_ack = 1'b0;
        check("pre_rst_exec_req", imem_req, 0);
        #2 reset = 1'b1;
        #1;
        check("midrst_req", imem_req, 1);
        check("midrst_addr", imem_addr, 0);
        check("midrst_result", result, 0);
        check("midrst_zero", zero, 0);
        check("midrst_neg", negative, 0);
        check("midrst_retire", retire, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        exec(enc_r(ADD, 3'd6, 3'd1, 3'd5), 0);
        check("regs_cleared", result, 0);

        // Reset with a concurrent fetch acknowledge must not advance to EXEC.
        reset     = 1'b1;
        imem_ack  = 1'b1;
        imem_data = enc_i(LDI, 3'd2, 11'd9);
        @(negedge clk);
        reset    = 1'b0;
        imem_ack = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_ack_ignored_req", imem_req, 1);
        check("rst_ack_ignored_addr", imem_addr, 0);
        exec(enc_i(LDI, 3'd2, 11'd3), 0);

        exec(enc_j(HLT, 14'h0), 0);
        for (int i = 0; i < 20; i++) begin
            check("halt_hold_halted", halted, 1);
            check("halt_hold_req", imem_req, 0);
            check("halt_hold_retire", retire, 0);
            imem_ack = 1'b1;
            @(negedge clk);
        end
        imem_ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
